// File: rtl/csi2_rx_packet_parser_if.sv
// Byte-stream and packet-output bundle between the D-PHY HS receiver and the packet parser.
// The slave modport is the parser's view; the master modport is the producer/consumer side.
interface csi2_rx_packet_parser_if #(
  parameter int COUNT_W = 16
);
  logic [7:0]         RxDataHS;
  logic               RxValidHS;
  logic               RxActiveHS;
  logic               RxSyncHS;
  logic [7:0]         PktDataID;
  logic [15:0]        PktWordCount;
  logic               PktHdrValid;
  logic [7:0]         PktPayload;
  logic               PktPayloadValid;
  logic               PktPayloadFirst;
  logic               PktPayloadLast;
  logic               PktDone;
  logic               HdrErr;
  logic               CrcErr;
  logic               AbortErr;
  logic               ParserBusy;
  logic [COUNT_W-1:0] PktCount;

  modport slave (
    input  RxDataHS, RxValidHS, RxActiveHS, RxSyncHS,
    output PktDataID, PktWordCount, PktHdrValid, PktPayload, PktPayloadValid,
           PktPayloadFirst, PktPayloadLast, PktDone, HdrErr, CrcErr, AbortErr,
           ParserBusy, PktCount
  );

  modport master (
    output RxDataHS, RxValidHS, RxActiveHS, RxSyncHS,
    input  PktDataID, PktWordCount, PktHdrValid, PktPayload, PktPayloadValid,
           PktPayloadFirst, PktPayloadLast, PktDone, HdrErr, CrcErr, AbortErr,
           ParserBusy, PktCount
  );
endinterface

// File: rtl/csi2_rx_packet_parser.sv
// CSI-2 style packet parser: one packet per HS burst, header check, payload framing,
// CRC-16 (0x8408 reflected) footer check, error pulses and a saturating good-packet counter.
module csi2_rx_packet_parser #(
  parameter logic [15:0] MAX_WC  = 16'd4096,
  parameter int          COUNT_W = 16
) (
  input logic                     RxByteClkHS,
  input logic                     RxRst,
  csi2_rx_packet_parser_if.slave  bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_CRC, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [15:0]        pay_cnt_q, pay_cnt_d;
  logic [15:0]        wc_q, wc_d;
  logic [15:0]        crc_q, crc_d;
  logic [7:0]         crc_lo_q, crc_lo_d;
  logic [7:0]         hdr0_q, hdr0_d, hdr1_q, hdr1_d, hdr2_q, hdr2_d;
  logic [7:0]         data_id_q, data_id_d;
  logic [15:0]        word_count_q, word_count_d;
  logic [7:0]         payload_q, payload_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic               payload_valid_q, payload_valid_d;
  logic               first_q, first_d, last_q, last_d;
  logic               done_q, done_d, hdr_err_q, hdr_err_d;
  logic               crc_err_q, crc_err_d, abort_q, abort_d;
  logic               busy_q, busy_d;
  logic [COUNT_W-1:0] pkt_count_q, pkt_count_d;

  logic               accept;
  logic               count_inc;
  logic [15:0]        hdr_wc;
  logic               is_last;

  // One LSB-first byte step of the reflected CCITT polynomial.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign accept = bus.RxValidHS & bus.RxActiveHS;
  assign hdr_wc = {hdr2_q, hdr1_q};
  assign is_last = (pay_cnt_q == wc_q - 16'd1);

  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    pay_cnt_d       = pay_cnt_q;
    wc_d            = wc_q;
    crc_d           = crc_q;
    crc_lo_d        = crc_lo_q;
    hdr0_d          = hdr0_q;
    hdr1_d          = hdr1_q;
    hdr2_d          = hdr2_q;
    data_id_d       = data_id_q;
    word_count_d    = word_count_q;
    payload_d       = payload_q;
    hdr_valid_d     = 1'b0;
    payload_valid_d = 1'b0;
    first_d         = 1'b0;
    last_d          = 1'b0;
    done_d          = 1'b0;
    hdr_err_d       = 1'b0;
    crc_err_d       = 1'b0;
    abort_d         = 1'b0;
    count_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.RxSyncHS && bus.RxActiveHS) begin
          state_d    = ST_HDR;
          byte_cnt_d = 2'd0;
          if (accept) begin
            hdr0_d     = bus.RxDataHS;
            byte_cnt_d = 2'd1;
          end
        end
      end
      ST_HDR: begin
        if (!bus.RxActiveHS) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (accept) begin
          case (byte_cnt_q)
            2'd0: begin hdr0_d = bus.RxDataHS; byte_cnt_d = 2'd1; end
            2'd1: begin hdr1_d = bus.RxDataHS; byte_cnt_d = 2'd2; end
            2'd2: begin hdr2_d = bus.RxDataHS; byte_cnt_d = 2'd3; end
            default: begin
              state_d = ST_DRAIN;
              if (bus.RxDataHS != (hdr0_q ^ hdr1_q ^ hdr2_q)) begin
                hdr_err_d = 1'b1;
              end else if (hdr0_q[7:4] == 4'h0) begin
                data_id_d    = hdr0_q;
                word_count_d = hdr_wc;
                hdr_valid_d  = 1'b1;
                done_d       = 1'b1;
                count_inc    = 1'b1;
              end else if (hdr_wc > MAX_WC) begin
                hdr_err_d = 1'b1;
              end else begin
                data_id_d    = hdr0_q;
                word_count_d = hdr_wc;
                hdr_valid_d  = 1'b1;
                wc_d         = hdr_wc;
                crc_d        = 16'hFFFF;
                pay_cnt_d    = 16'd0;
                byte_cnt_d   = 2'd0;
                state_d      = (hdr_wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
              end
            end
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (!bus.RxActiveHS) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (accept) begin
          payload_d       = bus.RxDataHS;
          payload_valid_d = 1'b1;
          first_d         = (pay_cnt_q == 16'd0);
          last_d          = is_last;
          crc_d           = crc16_byte(crc_q, bus.RxDataHS);
          pay_cnt_d       = pay_cnt_q + 16'd1;
          if (is_last) begin
            state_d    = ST_CRC;
            byte_cnt_d = 2'd0;
          end
        end
      end
      ST_CRC: begin
        if (!bus.RxActiveHS) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            crc_lo_d   = bus.RxDataHS;
            byte_cnt_d = 2'd1;
          end else begin
            state_d = ST_DRAIN;
            if ({bus.RxDataHS, crc_lo_q} == crc_q) begin
              done_d    = 1'b1;
              count_inc = 1'b1;
            end else begin
              crc_err_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (!bus.RxActiveHS) state_d = ST_IDLE;
      end
    endcase

    pkt_count_d = pkt_count_q;
    if (count_inc && (pkt_count_q != {COUNT_W{1'b1}})) begin
      pkt_count_d = pkt_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge RxByteClkHS or posedge RxRst) begin
    if (RxRst) begin
      state_q         <= ST_IDLE;
      byte_cnt_q      <= 2'd0;
      pay_cnt_q       <= 16'd0;
      wc_q            <= 16'd0;
      crc_q           <= 16'hFFFF;
      crc_lo_q        <= 8'd0;
      hdr0_q          <= 8'd0;
      hdr1_q          <= 8'd0;
      hdr2_q          <= 8'd0;
      data_id_q       <= 8'd0;
      word_count_q    <= 16'd0;
      payload_q       <= 8'd0;
      hdr_valid_q     <= 1'b0;
      payload_valid_q <= 1'b0;
      first_q         <= 1'b0;
      last_q          <= 1'b0;
      done_q          <= 1'b0;
      hdr_err_q       <= 1'b0;
      crc_err_q       <= 1'b0;
      abort_q         <= 1'b0;
      busy_q          <= 1'b0;
      pkt_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      pay_cnt_q       <= pay_cnt_d;
      wc_q            <= wc_d;
      crc_q           <= crc_d;
      crc_lo_q        <= crc_lo_d;
      hdr0_q          <= hdr0_d;
      hdr1_q          <= hdr1_d;
      hdr2_q          <= hdr2_d;
      data_id_q       <= data_id_d;
      word_count_q    <= word_count_d;
      payload_q       <= payload_d;
      hdr_valid_q     <= hdr_valid_d;
      payload_valid_q <= payload_valid_d;
      first_q         <= first_d;
      last_q          <= last_d;
      done_q          <= done_d;
      hdr_err_q       <= hdr_err_d;
      crc_err_q       <= crc_err_d;
      abort_q         <= abort_d;
      busy_q          <= busy_d;
      pkt_count_q     <= pkt_count_d;
    end
  end

  assign bus.PktDataID       = data_id_q;
  assign bus.PktWordCount    = word_count_q;
  assign bus.PktHdrValid     = hdr_valid_q;
  assign bus.PktPayload      = payload_q;
  assign bus.PktPayloadValid = payload_valid_q;
  assign bus.PktPayloadFirst = first_q;
  assign bus.PktPayloadLast  = last_q;
  assign bus.PktDone         = done_q;
  assign bus.HdrErr          = hdr_err_q;
  assign bus.CrcErr          = crc_err_q;
  assign bus.AbortErr        = abort_q;
  assign bus.ParserBusy      = busy_q;
  assign bus.PktCount        = pkt_count_q;

endmodule

// File: tb/tb_csi2_rx_packet_parser.sv
// Directed bench for csi2_rx_packet_parser: expected header/pulse events and payload bytes
// are queued as stimulus is driven and popped by a negedge monitor as the parser emits them.
module tb_csi2_rx_packet_parser;

  typedef struct packed {
    logic [4:0]  flags;   // {hdr_valid, done, hdr_err, crc_err, abort}
    logic [7:0]  id;
    logic [15:0] wc;
    logic [15:0] cnt;
  } ev_t;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } pay_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_count;
  ev_t  ev_q[$];
  pay_t pay_q[$];
  logic [7:0] pay[$];

  csi2_rx_packet_parser_if #(.COUNT_W(16)) bus ();

  csi2_rx_packet_parser #(.MAX_WC(16'd4096), .COUNT_W(16)) dut (
    .RxByteClkHS(clk),
    .RxRst      (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] crcModel(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  task automatic pushEvent(input logic [4:0] flags, input logic [7:0] id, input logic [15:0] wc);
    ev_t e;
    e.flags = flags;
    e.id    = id;
    e.wc    = wc;
    e.cnt   = exp_count[15:0];
    ev_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit sync);
    @(negedge clk);
    bus.RxDataHS   = b;
    bus.RxValidHS  = 1'b1;
    bus.RxActiveHS = 1'b1;
    bus.RxSyncHS   = sync;
  endtask

  task automatic gapCycle();
    @(negedge clk);
    bus.RxValidHS  = 1'b0;
    bus.RxActiveHS = 1'b1;
    bus.RxSyncHS   = 1'b0;
  endtask

  task automatic startBurst();
    @(negedge clk);
    bus.RxValidHS  = 1'b0;
    bus.RxActiveHS = 1'b1;
    bus.RxSyncHS   = 1'b1;
  endtask

  task automatic endBurst(input bit aborted);
    @(negedge clk);
    bus.RxValidHS  = 1'b0;
    bus.RxActiveHS = 1'b0;
    bus.RxSyncHS   = 1'b0;
    if (aborted) pushEvent(5'b00001, 8'h00, 16'h0000);
    repeat (2) @(negedge clk);
  endtask

  // Bounded wait for every queued expectation to be consumed by the monitor.
  task automatic waitDrained(input string tag);
    for (int i = 0; i < 8 && (ev_q.size() != 0 || pay_q.size() != 0); i++) @(negedge clk);
    checkOutput({tag, "_events_left"}, ev_q.size(), 0);
    checkOutput({tag, "_payload_left"}, pay_q.size(), 0);
  endtask

  task automatic sendLong(input logic [7:0] id, input logic [15:0] rx_crc, input bit good,
                          input bit gaps, input int trailer);
    logic [15:0] wc;
    logic [7:0]  chk;
    pay_t        p;
    wc  = 16'(pay.size());
    chk = id ^ wc[7:0] ^ wc[15:8];
    startBurst();
    applyStimulus(id, 1'b0);
    applyStimulus(wc[7:0], 1'b0);
    applyStimulus(wc[15:8], 1'b0);
    pushEvent(5'b10000, id, wc);
    applyStimulus(chk, 1'b0);
    for (int i = 0; i < pay.size(); i++) begin
      p.d = pay[i];
      p.f = (i == 0);
      p.l = (i == pay.size() - 1);
      pay_q.push_back(p);
      applyStimulus(pay[i], gaps && (i == 1));
      if (gaps) gapCycle();
    end
    applyStimulus(rx_crc[7:0], 1'b0);
    if (good) begin
      exp_count++;
      pushEvent(5'b01000, 8'h00, 16'h0000);
    end else begin
      pushEvent(5'b00010, 8'h00, 16'h0000);
    end
    applyStimulus(rx_crc[15:8], 1'b0);
    for (int i = 0; i < trailer; i++) applyStimulus(8'hA0 + 8'(i), 1'b0);
    endBurst(1'b0);
  endtask

  task automatic sendShort(input logic [7:0] id, input logic [15:0] data);
    applyStimulus(id, 1'b1);
    applyStimulus(data[7:0], 1'b0);
    applyStimulus(data[15:8], 1'b0);
    exp_count++;
    pushEvent(5'b11000, id, data);
    applyStimulus(id ^ data[7:0] ^ data[15:8], 1'b0);
    applyStimulus(8'h77, 1'b0);
    endBurst(1'b0);
  endtask

  // Scoreboard monitor: every pulse or payload beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.PktPayloadValid) begin
        checkOutput("payload_expected", pay_q.size() != 0, 1);
        if (pay_q.size() != 0) begin
          pay_t p;
          p = pay_q.pop_front();
          checkOutput("payload_beat", {bus.PktPayload, bus.PktPayloadFirst, bus.PktPayloadLast}, p);
        end
      end
      if ({bus.PktHdrValid, bus.PktDone, bus.HdrErr, bus.CrcErr, bus.AbortErr} != 5'b0) begin
        checkOutput("event_expected", ev_q.size() != 0, 1);
        if (ev_q.size() != 0) begin
          ev_t e;
          e = ev_q.pop_front();
          checkOutput("event_flags", {bus.PktHdrValid, bus.PktDone, bus.HdrErr, bus.CrcErr, bus.AbortErr}, e.flags);
          checkOutput("event_count", bus.PktCount, e.cnt);
          if (e.flags[4]) checkOutput("event_header", {bus.PktDataID, bus.PktWordCount}, {e.id, e.wc});
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    exp_count = 0;
    rst            = 1'b1;
    bus.RxDataHS   = 8'h00;
    bus.RxValidHS  = 1'b0;
    bus.RxActiveHS = 1'b0;
    bus.RxSyncHS   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
      {bus.PktDataID, bus.PktWordCount, bus.PktHdrValid, bus.PktPayload, bus.PktPayloadValid,
       bus.PktPayloadFirst, bus.PktPayloadLast, bus.PktDone, bus.HdrErr, bus.CrcErr,
       bus.AbortErr, bus.ParserBusy, bus.PktCount}, 64'd0);
    rst = 1'b0;
    $display("[TB] reset released");

    // Valid without Active in IDLE is not a byte.
    @(negedge clk);
    bus.RxDataHS  = 8'h2A;
    bus.RxValidHS = 1'b1;
    repeat (2) @(negedge clk);
    bus.RxValidHS = 1'b0;
    checkOutput("idle_busy", bus.ParserBusy, 0);

    sendShort(8'h00, 16'h1234);
    waitDrained("short");
    checkOutput("short_count", bus.PktCount, 16'd1);

    pay = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
            8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    sendLong(8'h2A, 16'h00F0, 1'b1, 1'b0, 2);
    waitDrained("long_good");
    sendLong(8'h2A, 16'h00F1, 1'b0, 1'b0, 0);
    waitDrained("long_badcrc");
    checkOutput("badcrc_count", bus.PktCount, 16'd2);

    // Header check failure, then an oversize word count; trailer bytes must be ignored.
    startBurst();
    applyStimulus(8'h2A, 1'b0);
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h00, 1'b0);
    pushEvent(5'b00100, 8'h00, 16'h0000);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b1);
    endBurst(1'b0);
    waitDrained("hdr_check");
    startBurst();
    applyStimulus(8'h2A, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h20, 1'b0);
    pushEvent(5'b00100, 8'h00, 16'h0000);
    applyStimulus(8'h0A, 1'b0);
    applyStimulus(8'h33, 1'b0);
    endBurst(1'b0);
    waitDrained("hdr_maxwc");
    checkOutput("hdr_hold", {bus.PktDataID, bus.PktWordCount}, {8'h2A, 16'h0018});

    // Burst drops after payload byte 5 of a 16-byte packet.
    startBurst();
    applyStimulus(8'h2A, 1'b0);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h00, 1'b0);
    pushEvent(5'b10000, 8'h2A, 16'h0010);
    applyStimulus(8'h3A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      pay_q.push_back({8'h40 + 8'(i), i == 0, 1'b0});
      applyStimulus(8'h40 + 8'(i), 1'b0);
    end
    checkOutput("abort_busy_mid", bus.ParserBusy, 1);
    endBurst(1'b1);
    waitDrained("abort");
    checkOutput("abort_busy_after", bus.ParserBusy, 0);

    pay = '{8'hA5};
    sendLong(8'h2A, crcModel(16'hFFFF, 8'hA5), 1'b1, 1'b0, 0);
    waitDrained("wc1");
    pay = {};
    sendLong(8'h2A, 16'hFFFF, 1'b1, 1'b0, 1);
    waitDrained("wc0");
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    sendLong(8'h2B, crcModel(crcModel(crcModel(crcModel(16'hFFFF, 8'h01), 8'h02), 8'h03), 8'h04),
             1'b1, 1'b1, 0);
    waitDrained("gaps");
    checkOutput("count_before_reset", bus.PktCount, 16'd5);

    // Asynchronous reset while a payload beat is on the outputs.
    startBurst();
    applyStimulus(8'h2A, 1'b0);
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h00, 1'b0);
    pushEvent(5'b10000, 8'h2A, 16'h0008);
    applyStimulus(8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pay_q.push_back({8'h10 + 8'(i), i == 0, 1'b0});
      applyStimulus(8'h10 + 8'(i), 1'b0);
    end
    @(posedge clk);
    #2;
    checkOutput("pre_reset_valid", {bus.PktPayloadValid, bus.ParserBusy}, 2'b11);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
      {bus.PktDataID, bus.PktWordCount, bus.PktHdrValid, bus.PktPayload, bus.PktPayloadValid,
       bus.PktPayloadFirst, bus.PktPayloadLast, bus.PktDone, bus.HdrErr, bus.CrcErr,
       bus.AbortErr, bus.ParserBusy, bus.PktCount}, 64'd0);
    bus.RxValidHS  = 1'b0;
    bus.RxActiveHS = 1'b0;
    pay_q.delete();
    ev_q.delete();
    exp_count = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    sendShort(8'h05, 16'h55AA);
    waitDrained("post_reset");
    checkOutput("final_count", bus.PktCount, exp_count[15:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
